// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared types and constants for the instruction-memory arbiter
package imem_pkg;

    typedef enum logic {
        BOOT = 1'b0,
        RUN  = 1'b1
    } imem_state_t;

    localparam logic [31:0] NOP            = 32'h0000_0013;
    localparam int          ADDR_W_DEFAULT = 8;

endpackage

// File: rtl/imem_arbiter_if.sv
// rtl/imem_arbiter_if.sv - single-port instruction memory bus between arbiter and M9K
interface imem_arbiter_if import imem_pkg::*; #(
    parameter int ADDR_W = ADDR_W_DEFAULT
) ();

    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic              mem_re;
    logic [31:0]       mem_wdata;
    logic [31:0]       mem_rdata;

    modport master (
        output mem_addr, mem_we, mem_re, mem_wdata,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr, mem_we, mem_re, mem_wdata,
        output mem_rdata
    );

endinterface

// File: rtl/imem_arb_grant.sv
// rtl/imem_arb_grant.sv - combinational port grant: fetch priority with a bounded loader window
module imem_arb_grant #(
    parameter int LOAD_BURST = 2,
    parameter int CNT_W      = 2
) (
    input  logic             active,
    input  logic             run,
    input  logic             fetch_req,
    input  logic             load_valid,
    input  logic [CNT_W-1:0] burst_cnt,
    output logic             fetch_gnt,
    output logic             load_gnt
);

    always_comb begin
        fetch_gnt = 1'b0;
        load_gnt  = 1'b0;
        if (active) begin
            if (!run) begin
                load_gnt = load_valid;
            end else if (fetch_req && load_valid) begin
                // Loader keeps the port until it has used its whole window.
                if (burst_cnt == CNT_W'(LOAD_BURST)) begin
                    fetch_gnt = 1'b1;
                end else begin
                    load_gnt = 1'b1;
                end
            end else begin
                fetch_gnt = fetch_req;
                load_gnt  = load_valid;
            end
        end
    end

endmodule

// File: rtl/imem_arbiter.sv
// rtl/imem_arbiter.sv - boot sequencer and fetch/loader arbiter; IMEM_ARB_RANGE_CHK_EN enables address-range faults
module imem_arbiter import imem_pkg::*; #(
    parameter int ADDR_W     = ADDR_W_DEFAULT,
    parameter int LOAD_BURST = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          fetch_req,
    input  logic [31:0]   fetch_addr,
    output logic          fetch_stall,
    output logic          fetch_valid,
    output logic [31:0]   fetch_rdata,
    output logic          fetch_fault,
    input  logic          load_valid,
    input  logic [31:0]   load_addr,
    input  logic [31:0]   load_wdata,
    output logic          load_ready,
    input  logic          load_done,
    output logic          cpu_run,
    imem_arbiter_if.master mem
);

    localparam int CNT_W = $clog2(LOAD_BURST + 1);

    imem_state_t      state;
    logic [CNT_W-1:0] burst_cnt;
    logic             fetch_gnt;
    logic             load_gnt;
    logic             fetch_oor;
    logic             load_oor;
    logic             unused_addr_bits;

    assign unused_addr_bits = ^{fetch_addr[1:0], load_addr[1:0],
                                fetch_addr[31:ADDR_W+2], load_addr[31:ADDR_W+2]};

`ifdef IMEM_ARB_RANGE_CHK_EN
    logic fault_q;
    assign fetch_oor   = |fetch_addr[31:ADDR_W+2];
    assign load_oor    = |load_addr[31:ADDR_W+2];
    assign fetch_fault = fault_q;
`else
    assign fetch_oor   = 1'b0;
    assign load_oor    = 1'b0;
    assign fetch_fault = 1'b0;
`endif

    imem_arb_grant #(
        .LOAD_BURST (LOAD_BURST),
        .CNT_W      (CNT_W)
    ) u_grant (
        .active     (rst_n),
        .run        (state == RUN),
        .fetch_req  (fetch_req),
        .load_valid (load_valid),
        .burst_cnt  (burst_cnt),
        .fetch_gnt  (fetch_gnt),
        .load_gnt   (load_gnt)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= BOOT;
            cpu_run     <= 1'b0;
            fetch_valid <= 1'b0;
            burst_cnt   <= '0;
`ifdef IMEM_ARB_RANGE_CHK_EN
            fault_q     <= 1'b0;
`endif
        end else begin
            fetch_valid <= fetch_gnt;
`ifdef IMEM_ARB_RANGE_CHK_EN
            fault_q     <= fetch_gnt & fetch_oor;
`endif
            if (state == BOOT) begin
                burst_cnt <= '0;
                if (load_done) begin
                    state   <= RUN;
                    cpu_run <= 1'b1;
                end
            end else if (fetch_gnt || !fetch_req) begin
                burst_cnt <= '0;
            end else if (load_gnt && burst_cnt != CNT_W'(LOAD_BURST)) begin
                burst_cnt <= burst_cnt + 1'b1;
            end
        end
    end

    // A faulted fetch still signals valid but must never expose stale RAM data.
    assign fetch_rdata   = (fetch_valid && !fetch_fault) ? mem.mem_rdata : NOP;
    assign fetch_stall   = fetch_req & ~fetch_gnt;
    assign load_ready    = load_gnt;
    assign mem.mem_re    = fetch_gnt & ~fetch_oor;
    assign mem.mem_we    = load_gnt & ~load_oor;
    assign mem.mem_addr  = fetch_gnt ? fetch_addr[ADDR_W+1:2] : load_addr[ADDR_W+1:2];
    assign mem.mem_wdata = load_wdata;

endmodule

// File: tb/tb_imem_arbiter.sv
// tb/tb_imem_arbiter.sv - randomized and directed checks of imem_arbiter against a behavioural model
module tb_imem_arbiter;

    localparam int          AW  = 8;
    localparam int          LB  = 2;
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        fetch_req, fetch_stall, fetch_valid, fetch_fault;
    logic [31:0] fetch_addr, fetch_rdata;
    logic        load_valid, load_ready, load_done, cpu_run;
    logic [31:0] load_addr, load_wdata;

    int checks   = 0;
    int failures = 0;

    imem_arbiter_if #(.ADDR_W(AW)) bus ();

    imem_arbiter #(.ADDR_W(AW), .LOAD_BURST(LB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .fetch_req   (fetch_req),
        .fetch_addr  (fetch_addr),
        .fetch_stall (fetch_stall),
        .fetch_valid (fetch_valid),
        .fetch_rdata (fetch_rdata),
        .fetch_fault (fetch_fault),
        .load_valid  (load_valid),
        .load_addr   (load_addr),
        .load_wdata  (load_wdata),
        .load_ready  (load_ready),
        .load_done   (load_done),
        .cpu_run     (cpu_run),
        .mem         (bus)
    );

    always #5 clk = ~clk;

    // M9K stand-in: write-through-edge, registered read.
    logic [31:0] ram [256];
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        if (bus.mem_re) bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic bit out_of_range(input logic [31:0] a);
`ifdef IMEM_ARB_RANGE_CHK_EN
        return (a >> (AW + 2)) != 0;
`else
        return (a == 32'hffff_ffff) && (a != 32'hffff_ffff);
`endif
    endfunction

    // Behavioural model: which requester owns the port, what the RAM holds, what arrives next cycle.
    logic [31:0] model_mem [256];
    bit          m_run, m_pv, m_pf;
    int          m_wins;
    logic [31:0] m_pd;

    initial begin
        bit fg, lg, of, ol;
        int fi, li;
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = '0;
            ram[i]       = '0;
        end
        m_run = 0; m_pv = 0; m_pf = 0; m_wins = 0; m_pd = NOP;
        @(posedge clk);
        forever begin
            @(negedge clk);
            of = out_of_range(fetch_addr);
            ol = out_of_range(load_addr);
            fi = int'(fetch_addr >> 2) % 256;
            li = int'(load_addr >> 2) % 256;
            fg = rst_n && m_run && fetch_req && (!load_valid || m_wins >= LB);
            lg = rst_n && load_valid && !fg;
            chk("m_fetch_stall", {31'b0, fetch_stall}, {31'b0, fetch_req && !fg});
            chk("m_load_ready", {31'b0, load_ready}, {31'b0, lg});
            chk("m_mem_re", {31'b0, bus.mem_re}, {31'b0, fg && !of});
            chk("m_mem_we", {31'b0, bus.mem_we}, {31'b0, lg && !ol});
            if (fg) chk("m_mem_addr_f", {24'b0, bus.mem_addr}, fi);
            else if (lg) chk("m_mem_addr_l", {24'b0, bus.mem_addr}, li);
            if (lg && !ol) chk("m_mem_wdata", bus.mem_wdata, load_wdata);
            chk("m_cpu_run", {31'b0, cpu_run}, {31'b0, m_run});
            chk("m_fetch_valid", {31'b0, fetch_valid}, {31'b0, m_pv});
            chk("m_fetch_rdata", fetch_rdata, m_pv ? m_pd : NOP);
            chk("m_fetch_fault", {31'b0, fetch_fault}, {31'b0, m_pf});
            @(posedge clk);
            if (!rst_n) begin
                m_run = 0; m_wins = 0; m_pv = 0; m_pf = 0;
            end else begin
                m_pv = fg;
                m_pf = fg && of;
                m_pd = (fg && !of) ? model_mem[fi] : NOP;
                if (lg && !ol) model_mem[li] = load_wdata;
                if (!m_run) begin
                    m_wins = 0;
                    if (load_done) m_run = 1;
                end else if (fg || !fetch_req) begin
                    m_wins = 0;
                end else if (lg && m_wins < LB) begin
                    m_wins++;
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        string pat;
        rst_n = 0; fetch_req = 0; fetch_addr = 0; load_valid = 0;
        load_addr = 0; load_wdata = 0; load_done = 0;
        step(); step();
        #2;
        chk("rst_cpu_run", {31'b0, cpu_run}, 32'd0);
        chk("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
        rst_n = 1;

        fetch_req = 1;
        for (int i = 0; i < 3; i++) begin
            #2;
            chk("boot_stall", {31'b0, fetch_stall}, 32'd1);
            chk("boot_re", {31'b0, bus.mem_re}, 32'd0);
            step();
        end
        fetch_req = 0;

        load_valid = 1; load_addr = 32'h0; load_wdata = 32'h0800_0313;
        #2;
        chk("boot_load_ready", {31'b0, load_ready}, 32'd1);
        chk("boot_we", {31'b0, bus.mem_we}, 32'd1);
        step();
        load_addr = 32'h4; load_wdata = 32'h0003_2383; load_done = 1;
        step();
        load_valid = 0; load_done = 0;
        fetch_req = 1; fetch_addr = 32'h0;
        #2;
        chk("run_cpu_run", {31'b0, cpu_run}, 32'd1);
        step();
        fetch_addr = 32'h4;
        #2;
        chk("fetch0_valid", {31'b0, fetch_valid}, 32'd1);
        chk("fetch0_data", fetch_rdata, 32'h0800_0313);
        step();
        fetch_req = 0;
        #2;
        chk("fetch4_data", fetch_rdata, 32'h0003_2383);
        step();

        fetch_req = 1; fetch_addr = 32'h8; load_valid = 1; load_addr = 32'h40;
        pat = "LLFLLF";
        for (int i = 0; i < 6; i++) begin
            load_wdata = $urandom;
            #2;
            chk("burst_pattern", {24'b0, bus.mem_re ? "F" : (load_ready ? "L" : "-")}, {24'b0, pat[i]});
            chk("burst_stall", {31'b0, fetch_stall}, {31'b0, pat[i] == "L"});
            step();
        end

        fetch_req = 0; load_addr = 32'h10; load_wdata = NOP;
        step();
        load_valid = 0; fetch_req = 1; fetch_addr = 32'h10;
        step();
        fetch_req = 0;
        #2;
        chk("raw_data", fetch_rdata, NOP);
        step();

        fetch_req = 1; fetch_addr = 32'h400;
        #2;
`ifdef IMEM_ARB_RANGE_CHK_EN
        chk("oor_re", {31'b0, bus.mem_re}, 32'd0);
`else
        chk("wrap_re", {31'b0, bus.mem_re}, 32'd1);
        chk("wrap_addr", {24'b0, bus.mem_addr}, 32'd0);
`endif
        step();
        fetch_addr = 32'h4;
        #2;
`ifdef IMEM_ARB_RANGE_CHK_EN
        chk("oor_fault", {31'b0, fetch_fault}, 32'd1);
        chk("oor_data", fetch_rdata, NOP);
`else
        chk("wrap_fault", {31'b0, fetch_fault}, 32'd0);
        chk("wrap_data", fetch_rdata, 32'h0800_0313);
`endif
        step();

        rst_n = 0; load_valid = 1; load_addr = 32'h20;
        #2;
        chk("rst_re", {31'b0, bus.mem_re}, 32'd0);
        chk("rst_load_ready", {31'b0, load_ready}, 32'd0);
        chk("rst_stall", {31'b0, fetch_stall}, 32'd1);
        step();
        #2;
        chk("rst_mid_valid", {31'b0, fetch_valid}, 32'd0);
        chk("rst_mid_run", {31'b0, cpu_run}, 32'd0);
        rst_n = 1; load_valid = 0;
        step();
        #2;
        chk("reboot_stall", {31'b0, fetch_stall}, 32'd1);

        for (int c = 0; c < 3000; c++) begin
            rst_n      = ($urandom_range(0, 299) != 0);
            fetch_req  = ($urandom_range(0, 3) != 0);
            fetch_addr = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) fetch_addr |= 32'h1 << $urandom_range(10, 31);
            load_valid = $urandom_range(0, 1);
            load_addr  = ($urandom_range(0, 63) << 2) | $urandom_range(0, 3);
            if ($urandom_range(0, 7) == 0) load_addr |= 32'h1 << $urandom_range(10, 31);
            load_wdata = $urandom;
            load_done  = ($urandom_range(0, 15) == 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_arbiter.md
# imem_arbiter

Sequencer and arbiter for the 256-word M9K instruction memory. It owns the memory's single port and shares it between the pipeline's fetch stage and the boot/patch loader (UART programmer). It holds the core in reset-like BOOT until the image is loaded, then gives fetch priority with a bounded loader window so live patching can neither starve fetch nor be starved by it.

## Interface
- ADDR_W, 8, word-address bits; depth 2^ADDR_W words
- LOAD_BURST, 2, max consecutive loader grants while fetch is waiting
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- fetch_req  in  1  fetch stage requests an instruction
- fetch_addr  in  32  byte address; word index = fetch_addr[ADDR_W+1:2]
- fetch_stall  out  1  request not granted this cycle; hold PC
- fetch_valid  out  1  fetch_rdata valid (one cycle after grant)
- fetch_rdata  out  32  instruction word
- fetch_fault  out  1  address-range fault (see Configuration)
- load_valid  in  1  loader has a write pending
- load_addr  in  32  byte address of write
- load_wdata  in  32  instruction word to write
- load_ready  out  1  write accepted this cycle
- load_done  in  1  single-cycle pulse: boot image complete
- cpu_run  out  1  releases the pipeline
- mem_addr  out  ADDR_W  word address to memory
- mem_we  out  1  memory write enable
- mem_re  out  1  memory read enable
- mem_wdata  out  32  memory write data
- mem_rdata  in  32  memory read data, registered, 1-cycle latency

## Operation
- States: BOOT (reset state), RUN.
- BOOT: only loader traffic. load_valid → load_ready=1, mem_we=1, same cycle. fetch_stall=1, cpu_run=0. load_done → RUN next cycle. A write in the same cycle as load_done is still performed.
- RUN: cpu_run=1. Per cycle, one grant:
  - only fetch_req → fetch grant (mem_re=1).
  - only load_valid → loader grant.
  - both → loader wins unless burst counter == LOAD_BURST, then fetch wins.
- Burst counter: increments on each loader grant while fetch_req=1. It clears on any fetch grant or when fetch_req=0. It saturates at LOAD_BURST.
- fetch_stall = fetch_req & ~fetch grant.
- Fetch grant drives mem_addr from fetch_addr. Loader grant drives mem_addr from load_addr. Address bits [1:0] are ignored. Upper bits above ADDR_W+1 are dropped (wrap-around) unless range check is enabled.
- fetch_rdata = mem_rdata when fetch_valid, else 0x00000013 (NOP).
- load_done in RUN is ignored. Return to BOOT only via reset.
- Reset mid-operation: any in-flight read is discarded. fetch_valid clears the next edge. State returns to BOOT.

## Timing
- Fetch latency: grant in cycle N → fetch_valid=1 and data in N+1. Back-to-back fetches give one word per cycle.
- Loader write completes in the grant cycle. A fetch of the same word at N+1 returns the new data.
- Registered outputs, with values while rst_n=0: state=BOOT, cpu_run=0, fetch_valid=0, fetch_fault=0, burst counter=0.
- Combinational outputs while rst_n=0: mem_we=0, mem_re=0, load_ready=0, fetch_stall=fetch_req.
- Worst-case fetch wait in RUN: LOAD_BURST cycles.

## Configuration
- IMEM_ARB_RANGE_CHK_EN defined:
  - a fetch grant with any fetch_addr bit above ADDR_W+1 set performs no memory read (mem_re=0).
  - Next cycle: fetch_valid=1, fetch_rdata=NOP, fetch_fault=1 for one cycle.
  - An out-of-range loader write is accepted (load_ready=1) with mem_we=0.
- Undefined: addresses wrap modulo depth, and fetch_fault is tied 0.

## Structure
- Shared package imem_pkg holds:
  - state enum (BOOT, RUN)
  - NOP constant 32'h00000013
  - default ADDR_W
- One sub-module, imem_arb_grant: pure-combinational priority plus burst-counter compare. It returns fetch_gnt and load_gnt. State, counter and output registers stay in the top.

## Test plan
- Reset, then loader writes 0x08000313 @0x0 and 0x00032383 @0x4, then load_done → cpu_run=1 the next cycle; fetch 0x0 and 0x4 back-to-back return both words at N+1 and N+2.
- fetch_req held in BOOT → fetch_stall=1 every cycle, mem_re=0, fetch_valid=0.
- RUN, fetch_req=1 and load_valid=1 continuously, LOAD_BURST=2 → grant pattern L,L,F,L,L,F; fetch_stall high on loader cycles.
- Loader write 0x00000013 @0x10 at cycle N, fetch 0x10 at N+1 → fetch_rdata=0x00000013 at N+2.
- rst_n low for one cycle right after a fetch grant → fetch_valid=0 the next cycle, state=BOOT, cpu_run=0.
- With IMEM_ARB_RANGE_CHK_EN, fetch 0x400 (ADDR_W=8) → mem_re=0; next cycle fetch_fault=1, fetch_rdata=0x00000013. Without it, the same fetch returns word 0.
